// File: rtl/cla_multiword_seq.sv
// ---------------------------------------------------------------------------
// cla_multiword_seq
//
// Multi-precision add/subtract sequencer. A WORDS x 16-bit operation is
// carried out one 16-bit slice per clock through a single shared
// carry-lookahead adder, least-significant slice first. The carry out of
// each slice is registered and fed into the next slice's carry in, so a
// W-bit operation costs one adder and WORDS cycles.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   request; only sampled in IDLE or DONE
//   sub        in   0: a + b + carry_in   1: a - b (carry_in ignored)
//   carry_in   in   initial carry for add
//   a, b       in   W-bit operands
//   busy       out  high while an operation is in flight (RUN)
//   done       out  one-cycle pulse, result valid from this cycle on
//   sum        out  W-bit result, held until overwritten by the next op
//   carry_out  out  carry out of the top slice (for sub: 1 = no borrow)
//   overflow   out  signed two's-complement overflow of the W-bit result
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla_adder16
//
// Purely combinational 16-bit two-level carry-lookahead adder: four 4-bit
// lookahead groups, with a second lookahead level across the groups.
//
// Ports
//   a_i, b_i   in   16-bit addends
//   c_i        in   carry in
//   s_o        out  16-bit sum
//   c_o        out  carry out of bit 15
// ---------------------------------------------------------------------------
module cla_adder16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [15:0] g;       // bit generate
    logic [15:0] p;       // bit propagate
    logic [3:0]  grp_g;   // group generate
    logic [3:0]  grp_p;   // group propagate
    logic [4:0]  grp_c;   // carry into each group, grp_c[4] is the carry out
    logic [15:0] c;       // carry into each bit

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Group generate/propagate for each 4-bit group.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // Second lookahead level: every group carry is a flat function of c_i.
    assign grp_c[0] = c_i;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & c_i);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & c_i);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & c_i);
    assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                    | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c_i);

    // First lookahead level: bit carries inside each group from its group carry.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    assign s_o = p ^ c;
    assign c_o = grp_c[4];

endmodule

module cla_multiword_seq #(
    parameter int WORDS = 4,
    parameter int CW    = ($clog2(WORDS) < 1) ? 1 : $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                sub,
    input  logic                carry_in,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       carry_q, carry_d;
    // Operands are latched as slice arrays so the counter indexes them directly.
    // b_q already holds the effective operand (~b for subtract), which makes
    // the latched sub flag redundant once the initial carry has been chosen.
    logic [WORDS-1:0][15:0]     a_q, a_d;
    logic [WORDS-1:0][15:0]     b_q, b_d;
    logic [WORDS-1:0][15:0]     sum_q, sum_d;
    logic                       cout_q, cout_d;
    logic                       ovf_q, ovf_d;

    logic [15:0]                add_s;
    logic                       add_c;

    cla_adder16 u_adder (
        .a_i (a_q[cnt_q]),
        .b_i (b_q[cnt_q]),
        .c_i (carry_q),
        .s_o (add_s),
        .c_o (add_c)
    );

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    // Subtract is a + ~b + 1: the +1 enters as the first carry.
                    carry_d = sub ? 1'b1 : carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[cnt_q] = add_s;
                carry_d      = add_c;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = add_c;
                    // Overflow when both effective operands share a sign that
                    // the result does not.
                    ovf_d   = (a_q[WORDS-1][15] == b_q[WORDS-1][15])
                           && (add_s[15] != a_q[WORDS-1][15]);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule
